// File: rtl/dghv_pkg.sv
// Shared widths and FSM state type for the DGHV decryption datapath.
package dghv_pkg;
  localparam int unsigned LAMBDA = 272;
  localparam int unsigned ETA    = 240;
  localparam int unsigned NU     = 16;
  localparam int unsigned GAMMA  = 544;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REDUCE = 2'd1,
    CENTER = 2'd2,
    DONE   = 2'd3
  } dghv_state_e;
endpackage

// File: rtl/serial_mod_step.sv
// One MSB-first modular reduction step: r_next = (2r + bit) mod p, given r < p.
module serial_mod_step #(
  parameter int unsigned KEY_W = 272
) (
  input  logic [KEY_W:0]   r,
  input  logic             bit_in,
  input  logic [KEY_W-1:0] p,
  output logic [KEY_W:0]   r_next
);
  logic [KEY_W+1:0] w_t;
  logic [KEY_W+1:0] w_p_ext;
  logic [KEY_W+1:0] w_diff;

  // 2r + bit < 2p, so one conditional subtraction always suffices
  always_comb begin
    w_t     = {r, bit_in};
    w_p_ext = {2'b00, p};
    w_diff  = w_t - w_p_ext;
    if (w_t >= w_p_ext) r_next = w_diff[KEY_W:0];
    else                r_next = w_t[KEY_W:0];
  end
endmodule

// File: rtl/dghv_decrypt.sv
// DGHV bit decryption: msg = centred(c mod p) mod 2, reduced serially MSB-first.
// Optional key rejection (even/zero p) enabled by DGHV_DECRYPT_KEY_CHECK_EN.
module dghv_decrypt
  import dghv_pkg::*;
#(
  parameter int unsigned KEY_W = LAMBDA,
  parameter int unsigned CT_W  = GAMMA
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [KEY_W-1:0] key,
  input  logic [CT_W-1:0]  ct,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             msg,
  output logic             err,
  output logic             out_valid,
  input  logic             out_ready
);
  localparam int unsigned CNT_W = (CT_W > 1) ? $clog2(CT_W) : 1;

  dghv_state_e r_state, w_state_next;
  logic [KEY_W-1:0] r_key;
  logic [CT_W-1:0]  r_ct;
  logic [KEY_W:0]   r_r;
  logic [CNT_W-1:0] r_cnt;
  logic             r_msg;
  logic [KEY_W:0]   w_r_next;
  logic             w_accept;
  logic             w_last_bit;
  logic             w_key_bad;
  logic             w_above_half;

  serial_mod_step #(.KEY_W(KEY_W)) u_step (
    .r      (r_r),
    .bit_in (r_ct[CT_W-1]),
    .p      (r_key),
    .r_next (w_r_next)
  );

  assign in_ready   = (r_state == IDLE);
  assign out_valid  = (r_state == DONE);
  assign msg        = r_msg;
  assign w_accept   = in_valid && in_ready;
  assign w_last_bit = (r_cnt == CNT_W'(CT_W - 1));

`ifdef DGHV_DECRYPT_KEY_CHECK_EN
  logic r_err;
  assign w_key_bad = ~key[0];
  assign err       = r_err;

  always_ff @(posedge clk) begin
    if (reset)                 r_err <= 1'b0;
    else if (w_accept)         r_err <= w_key_bad;
    else if (out_valid && out_ready) r_err <= 1'b0;
  end
`else
  assign w_key_bad = 1'b0;
  assign err       = 1'b0;
`endif

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_state_next = w_key_bad ? DONE : REDUCE;
      REDUCE:  if (w_last_bit) w_state_next = CENTER;
      CENTER:  w_state_next = DONE;
      DONE:    if (out_ready) w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // Centring only flips parity when r maps to r - p, i.e. by p[0]
  assign w_above_half = (r_r > {2'b00, r_key[KEY_W-1:1]});

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_key   <= '0;
      r_ct    <= '0;
      r_r     <= '0;
      r_cnt   <= '0;
      r_msg   <= 1'b0;
    end else begin
      r_state <= w_state_next;
      case (r_state)
        IDLE: if (w_accept) begin
          r_key <= key;
          r_ct  <= ct;
          r_r   <= '0;
          r_cnt <= '0;
          r_msg <= 1'b0;
        end
        REDUCE: begin
          r_r   <= w_r_next;
          r_ct  <= {r_ct[CT_W-2:0], 1'b0};
          r_cnt <= r_cnt + 1'b1;
        end
        CENTER:  r_msg <= r_r[0] ^ (w_above_half & r_key[0]);
        default: ;
      endcase
    end
  end
endmodule
